cgra_config_sequencer: RTL

Control block that brings up the CGRA array and sequences each run: it holds the array in reset, streams configuration (address, data) words from a valid/ready source onto the array's config_addr/config_data bus, waits a settle interval, then enables the run for a programmed number of cycles and flags completion. It sits between the config-word source (bitstream memory or host FIFO) and the `top` CGRA instance, driving its reset and configuration inputs. Config address 0 is the bus no-op and is never issued as a real write.

---
 rtl/cgra_config_sequencer_if.sv | 28 ++
 rtl/cgra_config_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/cgra_config_sequencer_if.sv
// Config-word stream between the bitstream source and the sequencer.
// The master drives words; the slave (sequencer) returns ready.
interface cgra_config_sequencer_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_data;
    logic              cfg_last;

    modport master (
        output cfg_valid,
        output cfg_addr,
        output cfg_data,
        output cfg_last,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_addr,
        input  cfg_data,
        input  cfg_last,
        output cfg_ready
    );
endinterface

// File: rtl/cgra_config_sequencer.sv
// CGRA bring-up sequencer: holds the array in reset, streams config words onto
// the array config bus, waits a settle interval, then opens a run window of a
// programmed length and flags completion.
module cgra_config_sequencer #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned RESET_CYCLES  = 3,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CYCLE_W       = 20
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic                   start_in,
    input  logic [CYCLE_W-1:0]     run_cycles_in,
    cgra_config_sequencer_if.slave cfg,
    output logic                   cgra_reset_out,
    output logic [ADDR_W-1:0]      config_addr_out,
    output logic [DATA_W-1:0]      config_data_out,
    output logic                   run_en_out,
    output logic [15:0]            word_count_out,
    output logic                   done_out,
    output logic                   err_out
);

    // One down-counter serves the reset hold, settle and run phases.
    localparam int unsigned        CntW   = (CYCLE_W > 16) ? CYCLE_W : 16;
    localparam logic [CntW-1:0]    CntOne = CntW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StResetHold,
        StConfig,
        StSettle,
        StRun,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [CYCLE_W-1:0]  run_len_q, run_len_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [15:0]         word_count_q, word_count_d;
    logic                err_q, err_d;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            run_len_q    <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            word_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            run_len_q    <= run_len_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            word_count_q <= word_count_d;
            err_q        <= err_d;
        end
    end

    // Next-state, phase counter and config-bus register update.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        run_len_d    = run_len_q;
        // The bus carries a word for exactly one cycle, then returns to no-op.
        addr_d       = '0;
        data_d       = '0;
        word_count_d = word_count_q;
        err_d        = err_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start_in) begin
                    run_len_d    = run_cycles_in;
                    cnt_d        = CntW'(RESET_CYCLES - 1);
                    word_count_d = '0;
                    err_d        = 1'b0;
                    state_d      = StResetHold;
                end
            end

            StResetHold: begin
                if (cnt_q == '0) begin
                    state_d = StConfig;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end

            StConfig: begin
                if (cfg.cfg_valid) begin
                    if (cfg.cfg_addr != '0) begin
                        addr_d = cfg.cfg_addr;
                        data_d = cfg.cfg_data;
                        if (word_count_q != 16'hFFFF) begin
                            word_count_d = word_count_q + 16'd1;
                        end
                    end else begin
                        // Address 0 is the bus no-op: swallow it and flag the source.
                        err_d = 1'b1;
                    end
                    if (cfg.cfg_last) begin
                        cnt_d   = CntW'(SETTLE_CYCLES - 1);
                        state_d = StSettle;
                    end
                end
            end

            StSettle: begin
                if (cnt_q == '0) begin
                    if (run_len_q != '0) begin
                        cnt_d   = CntW'(run_len_q) - CntOne;
                        state_d = StRun;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end

            StRun: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from the current state and registered bus word.
    always_comb begin
        cgra_reset_out  = 1'b0;
        cfg.cfg_ready   = 1'b0;
        run_en_out      = 1'b0;
        done_out        = 1'b0;
        config_addr_out = addr_q;
        config_data_out = data_q;
        word_count_out  = word_count_q;
        err_out         = err_q;
        unique case (state_q)
            StResetHold: cgra_reset_out = 1'b1;
            StConfig:    cfg.cfg_ready  = 1'b1;
            StRun:       run_en_out     = 1'b1;
            StDone:      done_out       = 1'b1;
            default:     ;
        endcase
    end

endmodule
